ted_scandoubler: RTL

//  Line doubler that sits directly downstream of the TED colour LUT. It takes 4:4:4 RGB

---
 rtl/ted_scandoubler.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/ted_scandoubler.sv
// Line doubler for the TED video path: each input line is captured into one half of a
// ping-pong buffer while the previous line is replayed twice at double pixel rate.
module ted_scandoubler #(
  parameter int MAX_LINE = 512,
  parameter int IN_DIV   = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce_in,
  input  logic [3:0] red,
  input  logic [3:0] green,
  input  logic [3:0] blue,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       blank_in,
  output logic       ce_out,
  output logic [3:0] red_out,
  output logic [3:0] green_out,
  output logic [3:0] blue_out,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic       blank_out
);

  localparam int AW      = $clog2(MAX_LINE);
  localparam int OUT_DIV = IN_DIV / 2;
  localparam int DW      = (OUT_DIV > 1) ? $clog2(OUT_DIV) : 1;

  localparam logic [AW:0]   LINE_MAX = MAX_LINE[AW:0];
  localparam logic [DW-1:0] DIV_LAST = DW'(OUT_DIV - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_PASS_A = 2'd1;
  localparam logic [1:0] S_PASS_B = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  // Sync/blank arrive one clk ahead of the LUT colour; realign them here.
  logic hs_d_reg, vs_d_reg, bl_d_reg, hs_prev_reg;
  logic hrise;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_d_reg    <= 1'b0;
      vs_d_reg    <= 1'b0;
      bl_d_reg    <= 1'b0;
      hs_prev_reg <= 1'b0;
    end else begin
      hs_d_reg    <= hsync_in;
      vs_d_reg    <= vsync_in;
      bl_d_reg    <= blank_in;
      hs_prev_reg <= hs_d_reg;
    end
  end

  assign hrise = hs_d_reg & ~hs_prev_reg;

  // Write side
  logic          wsel_reg;
  logic [AW:0]   wr_x_reg, wr_x_next, wr_base;
  logic [AW:0]   hs_cnt_reg, hs_cnt_next, hs_base;
  logic [AW:0]   line_len_reg, hs_len_reg;
  logic          vs_line_reg;
  logic          wr_bank, wr_en;
  logic [AW:0]   wr_addr;
  logic [12:0]   wr_data;

  // An hrise restarts the line before a same-cycle pixel is stored, so that pixel
  // lands at address 0 of the freshly selected buffer.
  always_comb begin
    wr_base     = hrise ? '0 : wr_x_reg;
    wr_bank     = hrise ? ~wsel_reg : wsel_reg;
    wr_en       = ce_in && (wr_base < LINE_MAX);
    wr_x_next   = wr_en ? wr_base + 1'b1 : wr_base;
    hs_base     = hrise ? '0 : hs_cnt_reg;
    hs_cnt_next = (ce_in && hs_d_reg && (hs_base < LINE_MAX)) ? hs_base + 1'b1 : hs_base;
    wr_addr     = {wr_bank, wr_base[AW-1:0]};
    wr_data     = {bl_d_reg, bl_d_reg ? 12'h000 : {red, green, blue}};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wsel_reg     <= 1'b0;
      wr_x_reg     <= '0;
      hs_cnt_reg   <= '0;
      line_len_reg <= '0;
      hs_len_reg   <= '0;
      vs_line_reg  <= 1'b0;
    end else begin
      if (hrise) begin
        line_len_reg <= wr_x_reg;
        hs_len_reg   <= hs_cnt_reg;
        wsel_reg     <= ~wsel_reg;
        vs_line_reg  <= vs_d_reg;
      end
      wr_x_reg   <= wr_x_next;
      hs_cnt_reg <= hs_cnt_next;
    end
  end

  // Read side
  logic [1:0]    state_reg, state_next;
  logic [AW:0]   out_x_reg, out_x_next;
  logic [DW-1:0] div_reg, div_next;
  logic          out_ce, pass_last, in_pass;
  logic [AW:0]   rd_addr;

  // The slot coinciding with hrise is dropped: the timebase restarts there.
  assign out_ce    = (state_reg != S_IDLE) && !hrise && (div_reg == '0);
  assign pass_last = (out_x_reg == line_len_reg - 1'b1);
  assign in_pass   = (state_reg == S_PASS_A) || (state_reg == S_PASS_B);
  assign rd_addr   = {~wsel_reg, out_x_reg[AW-1:0]};

  always_comb begin
    state_next = state_reg;
    out_x_next = out_x_reg;
    div_next   = div_reg;
    if (hrise) begin
      state_next = (wr_x_reg == '0) ? S_HOLD : S_PASS_A;
      out_x_next = '0;
      div_next   = '0;
    end else if (state_reg != S_IDLE) begin
      div_next = (div_reg == DIV_LAST) ? '0 : div_reg + 1'b1;
      if (out_ce && in_pass) begin
        if (pass_last) begin
          out_x_next = '0;
          state_next = (state_reg == S_PASS_A) ? S_PASS_B : S_HOLD;
        end else begin
          out_x_next = out_x_reg + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= S_IDLE;
      out_x_reg <= '0;
      div_reg   <= '0;
    end else begin
      state_reg <= state_next;
      out_x_reg <= out_x_next;
      div_reg   <= div_next;
    end
  end

  // Both line buffers share one simple dual-port RAM, bank selected by the top address bit.
  logic [12:0] line_mem [0:2*MAX_LINE-1];
  logic [12:0] rd_data_reg;

  always_ff @(posedge clk) begin
    if (wr_en) line_mem[wr_addr] <= wr_data;
    if (out_ce) rd_data_reg <= line_mem[rd_addr];
  end

  // Output qualifiers, captured alongside the RAM read so everything holds between strobes
  logic ce_out_reg, pass_reg, oob_reg, hold_reg, hs_out_reg, vs_out_reg;
  logic show;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ce_out_reg <= 1'b0;
      pass_reg   <= 1'b0;
      oob_reg    <= 1'b0;
      hold_reg   <= 1'b0;
      hs_out_reg <= 1'b0;
      vs_out_reg <= 1'b0;
    end else begin
      ce_out_reg <= out_ce;
      if (out_ce) begin
        pass_reg   <= in_pass;
        oob_reg    <= out_x_reg[AW];
        hold_reg   <= (state_reg == S_HOLD);
        hs_out_reg <= in_pass && (out_x_reg < hs_len_reg);
        vs_out_reg <= vs_line_reg;
      end
    end
  end

  assign show      = pass_reg & ~oob_reg;
  assign ce_out    = ce_out_reg;
  assign hsync_out = hs_out_reg;
  assign vsync_out = vs_out_reg;
  assign blank_out = show ? rd_data_reg[12] : (pass_reg | hold_reg);
  assign {red_out, green_out, blue_out} = show ? rd_data_reg[11:0] : 12'h000;

endmodule
